uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter (11-bit frame: start, 8 data bits, parity, stop; 27 clk_3125 cycles per bit, 297 cycles per frame) between up to 8 byte-stream requesters. It sits between on-board message sources (sensor reporters, status/debug loggers) and the `uart_tx` instance, in the clk_3125 domain. It issues one start pulse per byte, waits for the transmitter's completion pulse, and keeps a grant locked across a multi-byte message so messages never interleave on the line.

## Interface
- `NUM_REQ`, 4, number of requesters, legal 2..8
- `TIMEOUT_CYCLES`, 320, maximum cycles in WAIT_DONE before abort; only used when `UART_ARB_TIMEOUT_EN` is defined

- `clk_3125`  in  1  3.125 MHz system clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  requester i has a byte on its data lane
- `req_data`  in  8*NUM_REQ  byte lanes; lane i = bits [8i+7:8i]
- `req_last`  in  NUM_REQ  byte on lane i is the final byte of its message
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse: lane i byte accepted
- `grant`  out  NUM_REQ  one-hot current/last owner; 0 when no lock and IDLE
- `tx_start`  out  1  one-cycle pulse to transmitter
- `tx_data`  out  8  byte to transmit; held stable from tx_start until tx_done
- `tx_done`  in  1  one-cycle pulse from transmitter after stop bit
- `busy`  out  1  high whenever state is not IDLE
- `timeout_err`  out  1  one-cycle pulse on transmitter timeout; constant 0 without macro

## Operation
- States: IDLE, WAIT_DONE.
- IDLE: candidate set = all lanes with `req_valid`=1; if lock is set, candidate set = owner lane only (others ignored even if valid).
- Winner = first candidate at or after priority pointer `ptr`, scanning upward with wrap at NUM_REQ.
- On the edge leaving IDLE with winner w: `tx_data` <= lane w, `tx_start` <= 1, `req_ready[w]` <= 1, `grant` <= one-hot w, `ptr` <= (w+1) mod NUM_REQ, state <= WAIT_DONE.
- Lock: set with owner w if accepted byte has `req_last`=0; cleared when accepted byte has `req_last`=1. Lock persists if owner's valid drops mid-message (arbiter waits in IDLE).
- WAIT_DONE: on `tx_done`=1 -> IDLE. `req_valid` changes ignored.
- `tx_done` while in IDLE: ignored.
- `grant` clears to 0 on return to IDLE only when lock is clear.
- Reset (asynchronous, any state, including mid-frame): state IDLE, `ptr`=0, lock clear, all outputs 0. Abandoned frame is not retried.

## Timing
- Data sampled at the edge where state leaves IDLE; `req_ready` and `tx_start` high during the following cycle (registered, 1-cycle latency). Requester holds data/valid until it sees `req_ready`, then advances on the next edge.
- Minimum spacing between tx_start pulses: tx_done cycle + 1 IDLE cycle; with 297-cycle frame, ~299 cycles per byte.
- `busy` high from the cycle of `tx_start` through the cycle of `tx_done`.
- `tx_data` never changes while `busy`=1.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined: 9-bit counter clears on entry to WAIT_DONE, increments each WAIT_DONE cycle; at TIMEOUT_CYCLES without `tx_done`: `timeout_err` pulses 1 cycle, lock clears, state -> IDLE. `tx_done` in the same cycle as expiry wins (normal completion, no error).
- Not defined: no counter; WAIT_DONE exits only on `tx_done`; `timeout_err` tied 0.

## Test plan
- Reset: hold `rst_n`=0 with all valids high -> all outputs 0, no `tx_start`; release -> first grant to lane 0, `tx_data`=lane 0 byte.
- Round-robin: lanes 0..3 all valid, last=1, bytes 0x41..0x44, model replies tx_done 297 cycles after each start -> tx_data sequence 0x41,0x42,0x43,0x44,0x41, exactly one `req_ready` pulse per start.
- Lock: lane 2 sends "OK\n" (last only on 0x0A) while lane 0 stays valid -> 0x4F,0x4B,0x0A contiguous, then lane 0 granted; lane 2 valid dropped 100 cycles between bytes -> arbiter idles, still no lane 0 grant.
- Stray/held done: tx_done pulse in IDLE -> no state change; tx_data stable for all 297 cycles of WAIT_DONE.
- Reset mid-frame: assert `rst_n`=0 150 cycles after tx_start with lock set -> busy=0, grant=0 immediately; after release, lowest valid lane from lane 0 wins.
- Timeout (macro defined): withhold tx_done -> `timeout_err` pulse at cycle 320 after entry, busy=0, lock cleared; tx_done coincident with cycle 320 -> no `timeout_err`.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Groups the requester byte lanes and the transmitter handshake that the
//   arbiter sits between.
//   master : requester/transmitter side (drives req_*, tx_done)
//   slave  : arbiter side (drives req_ready, grant, tx_*, busy, timeout_err)
//   req_data packs lane i in bits [8i+7:8i].
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_done;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, grant, tx_start, tx_data, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, grant, tx_start, tx_data, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one UART transmitter between NUM_REQ
//   byte-stream requesters. One tx_start per byte, waits for tx_done, and
//   keeps the grant locked across a multi-byte message (req_last marks the
//   final byte) so messages never interleave on the line.
//
//   Ports
//     clk_3125 : system clock, all logic on posedge
//     rst_n    : asynchronous active-low reset
//     bus      : uart_tx_arbiter_if.slave (req_valid/req_data/req_last/
//                req_ready, grant, tx_start/tx_data/tx_done, busy, timeout_err)
//
//   Optional feature: define UART_ARB_TIMEOUT_EN to abort WAIT_DONE after
//   TIMEOUT_CYCLES cycles without tx_done (pulses timeout_err, drops lock).
//   Without it timeout_err is constant 0.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 320
) (
    input  logic             clk_3125,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, WAIT_DONE} state_t;
    state_t state, state_nxt;

    logic [PW-1:0]      ptr, owner, win;
    logic               lock, win_vld, expire;
    logic [NUM_REQ-1:0] cand, req_ready_q, grant_q;
    logic               tx_start_q, timeout_q;
    logic [7:0]         tx_data_q, win_byte;

    // While locked only the owner may win, even if other lanes are valid.
    always_comb begin
        cand = bus.req_valid;
        if (lock) begin
            cand        = '0;
            cand[owner] = bus.req_valid[owner];
        end
    end

    // Scan from ptr upward with wrap. Walking offsets high-to-low leaves the
    // smallest offset (the first candidate at/after ptr) as the final write.
    always_comb begin
        logic [PW:0] idx;
        idx     = '0;
        win_vld = 1'b0;
        win     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_REQ))
                idx = idx - (PW+1)'(NUM_REQ);
            if (cand[idx[PW-1:0]]) begin
                win_vld = 1'b1;
                win     = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (win == PW'(k))
                win_byte = bus.req_data[8*k +: 8];
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [8:0] tcnt;

    // tcnt is 0 on the first WAIT_DONE cycle, so TIMEOUT_CYCLES-1 marks the
    // last allowed cycle; a tx_done in that same cycle still wins.
    assign expire = (state == WAIT_DONE) && !bus.tx_done &&
                    (tcnt == 9'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n)
            tcnt <= '0;
        else if (state == IDLE)
            tcnt <= '0;
        else
            tcnt <= tcnt + 9'd1;
    end
`else
    // No watchdog in this build; TIMEOUT_CYCLES has no effect here.
    assign expire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (win_vld) state_nxt = WAIT_DONE;
            WAIT_DONE: if (bus.tx_done || expire) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            owner       <= '0;
            lock        <= 1'b0;
            req_ready_q <= '0;
            grant_q     <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            req_ready_q <= '0;
            tx_start_q  <= 1'b0;
            timeout_q   <= 1'b0;
            if (state == IDLE && win_vld) begin
                tx_data_q   <= win_byte;
                tx_start_q  <= 1'b1;
                req_ready_q <= NUM_REQ'(1) << win;
                grant_q     <= NUM_REQ'(1) << win;
                ptr         <= (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
                owner       <= win;
                lock        <= !bus.req_last[win];
            end else if (state == WAIT_DONE && (bus.tx_done || expire)) begin
                // grant survives the return to IDLE only while a message is open
                if (!lock || expire)
                    grant_q <= '0;
                if (expire) begin
                    lock      <= 1'b0;
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.grant       = grant_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.busy        = (state == WAIT_DONE);
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk_3125 = 1'b0;
    logic rst_n;
    always #160 clk_3125 = ~clk_3125;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(320)) dut (
        .clk_3125 (clk_3125),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int errors = 0;
    int checks = 0;

    // Requester model: one queue of pending bytes per lane.
    logic [7:0] q_data [N][$];
    bit         q_last [N][$];
    bit         hold   [N];
    logic [7:0] seen   [$];

    // Arbitration model state (priority pointer, message lock).
    int m_ptr;
    int m_owner;
    bit m_lock;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0 ] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(int lane, logic [7:0] b, bit last);
        q_data[lane].push_back(b);
        q_last[lane].push_back(last);
    endtask

    task automatic drive_lanes();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]       = (q_data[i].size() > 0) && !hold[i];
            bus.req_data[8*i +: 8] = (q_data[i].size() > 0) ? q_data[i][0] : 8'h00;
            bus.req_last[i]        = (q_last[i].size() > 0) ? q_last[i][0] : 1'b0;
        end
    endtask

    function automatic bit lane_valid(int i);
        return (q_data[i].size() > 0) && !hold[i];
    endfunction

    // Which lane should win next: the lock owner if a message is open,
    // otherwise the first valid lane at or after the pointer.
    function automatic int exp_winner();
        if (m_lock)
            return lane_valid(m_owner) ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (lane_valid(i)) return i;
        end
        return -1;
    endfunction

    task automatic wait_start(int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk_3125);
            if (bus.tx_start === 1'b1) ok = 1'b1;
        end
    endtask

    // Serve n bytes as the transmitter: check each start against the model,
    // then reply tx_done d cycles after tx_start.
    task automatic run_bytes(int n, int dmin, int dmax);
        for (int t = 0; t < n; t++) begin
            bit         ok;
            bit         stable;
            int         w;
            int         d;
            logic [7:0] held;
            wait_start(400, ok);
            chk("start_seen", ok, 1);
            if (!ok) return;
            w = exp_winner();
            chk("winner_exists", (w >= 0), 1);
            if (w < 0) return;
            chk("tx_data", bus.tx_data, q_data[w][0]);
            chk("req_ready", bus.req_ready, 1 << w);
            chk("grant", bus.grant, 1 << w);
            chk("busy_at_start", bus.busy, 1);
            seen.push_back(bus.tx_data);
            m_ptr   = (w + 1) % N;
            m_lock  = !q_last[w][0];
            m_owner = w;
            void'(q_data[w].pop_front());
            void'(q_last[w].pop_front());
            drive_lanes();
            held   = bus.tx_data;
            stable = 1'b1;
            d      = $urandom_range(dmax, dmin);
            for (int c = 1; c <= d; c++) begin
                @(negedge clk_3125);
                if (c == d) bus.tx_done = 1'b1;
                if (bus.tx_data !== held || bus.busy !== 1'b1 ||
                    bus.tx_start !== 1'b0 || bus.req_ready !== '0)
                    stable = 1'b0;
            end
            chk("hold_in_wait_done", stable, 1);
            @(negedge clk_3125);
            bus.tx_done = 1'b0;
            chk("busy_after_done", bus.busy, 0);
            chk("grant_after_done", bus.grant, m_lock ? (1 << w) : 0);
        end
    endtask

    task automatic chk_seq(string tag, int n, logic [63:0] exp);
        chk({tag, "_len"}, seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            chk(tag, seen[i], exp[8*(n-1-i) +: 8]);
    endtask

    initial begin
        bit ok;
        bit stable;
        int tcyc;
        int tot;

        rst_n         = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_done   = 1'b0;
        m_ptr = 0; m_owner = 0; m_lock = 1'b0;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        #5 rst_n = 1'b0;

        // Reset held with all lanes valid; outputs must stay quiet.
        push(0, 8'h41, 1); push(0, 8'h41, 1);
        push(1, 8'h42, 1); push(2, 8'h43, 1); push(3, 8'h44, 1);
        drive_lanes();
        repeat (4) @(negedge clk_3125);
        chk("rst_tx_start", bus.tx_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_timeout_err", bus.timeout_err, 0);
        rst_n = 1'b1;

        // Round-robin over four always-valid lanes.
        seen.delete();
        run_bytes(5, 297, 297);
        chk_seq("rr_seq", 5, 64'h41_42_43_44_41);

        // Locked 3-byte message on lane 2 while lane 0 waits.
        seen.delete();
        push(2, 8'h4F, 0); push(2, 8'h4B, 0); push(2, 8'h0A, 1);
        push(0, 8'h30, 1);
        drive_lanes();
        run_bytes(4, 297, 297);
        chk_seq("lock_seq", 4, 64'h4F_4B_0A_30);

        // Owner drops valid mid-message: arbiter idles, lane 0 not granted.
        seen.delete();
        push(2, 8'h61, 0); push(2, 8'h62, 1); push(0, 8'h31, 1);
        drive_lanes();
        run_bytes(1, 50, 50);
        hold[2] = 1'b1;
        drive_lanes();
        stable = 1'b1;
        repeat (100) begin
            @(negedge clk_3125);
            if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0 ||
                bus.grant !== 4'b0100 || bus.req_ready !== '0)
                stable = 1'b0;
        end
        chk("lock_hold_idle", stable, 1);
        hold[2] = 1'b0;
        drive_lanes();
        run_bytes(2, 20, 20);
        chk_seq("drop_seq", 3, 64'h61_62_31);

        // Stray tx_done while idle.
        @(negedge clk_3125) bus.tx_done = 1'b1;
        @(negedge clk_3125) bus.tx_done = 1'b0;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk_3125);
            if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0 || bus.grant !== '0)
                stable = 1'b0;
        end
        chk("stray_done", stable, 1);
        seen.delete();
        push(3, 8'h77, 1);
        drive_lanes();
        run_bytes(1, 297, 297);
        chk_seq("after_stray", 1, 64'h77);

        // Reset mid-frame with lock set.
        seen.delete();
        push(1, 8'h51, 0); push(1, 8'h52, 1);
        drive_lanes();
        wait_start(400, ok);
        chk("mf_start", ok, 1);
        chk("mf_data", bus.tx_data, 8'h51);
        void'(q_data[1].pop_front());
        void'(q_last[1].pop_front());
        drive_lanes();
        repeat (150) @(negedge clk_3125);
        chk("mf_grant_pre", bus.grant, 4'b0010);
        push(3, 8'h53, 1);
        drive_lanes();
        rst_n = 1'b0;
        #1;
        chk("mf_busy", bus.busy, 0);
        chk("mf_grant", bus.grant, 0);
        chk("mf_tx_start", bus.tx_start, 0);
        m_ptr = 0; m_lock = 1'b0;
        @(negedge clk_3125) rst_n = 1'b1;
        run_bytes(2, 30, 30);
        chk_seq("mf_seq", 2, 64'h52_53);

`ifdef UART_ARB_TIMEOUT_EN
        // Withheld tx_done: abort on the 320th WAIT_DONE cycle, lock dropped.
        push(1, 8'hA1, 0); push(1, 8'hA2, 1); push(2, 8'hB0, 1);
        drive_lanes();
        wait_start(400, ok);
        chk("to_start", ok, 1);
        chk("to_data", bus.tx_data, 8'hA1);
        void'(q_data[1].pop_front());
        void'(q_last[1].pop_front());
        drive_lanes();
        m_ptr = 2; m_lock = 1'b0;
        tcyc = 0;
        for (int c = 1; c <= 400 && tcyc == 0; c++) begin
            @(negedge clk_3125);
            if (bus.timeout_err === 1'b1) tcyc = c;
        end
        chk("to_cycle", tcyc, 320);
        chk("to_busy", bus.busy, 0);
        chk("to_grant", bus.grant, 0);
        seen.delete();
        run_bytes(1, 319, 319);
        chk("to_coincident", bus.timeout_err, 0);
        run_bytes(1, 20, 20);
        chk_seq("to_seq", 2, 64'hB0_A2);
`else
        // No watchdog: WAIT_DONE holds until tx_done, however late.
        push(0, 8'h99, 1);
        drive_lanes();
        wait_start(400, ok);
        chk("nto_start", ok, 1);
        chk("nto_data", bus.tx_data, 8'h99);
        void'(q_data[0].pop_front());
        void'(q_last[0].pop_front());
        drive_lanes();
        m_ptr = 1; m_lock = 1'b0;
        stable = 1'b1;
        repeat (400) begin
            @(negedge clk_3125);
            if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) stable = 1'b0;
        end
        chk("no_timeout", stable, 1);
        bus.tx_done = 1'b1;
        @(negedge clk_3125) bus.tx_done = 1'b0;
        chk("late_done_idle", bus.busy, 0);
`endif

        // Randomized messages on random lanes with random transmitter latency.
        for (int r = 0; r < 40; r++) begin
            tot = 0;
            for (int i = 0; i < N; i++) begin
                if (q_data[i].size() == 0 && $urandom_range(1, 0) == 1) begin
                    int len;
                    len = $urandom_range(3, 1);
                    for (int b = 0; b < len; b++)
                        push(i, 8'($urandom), (b == len - 1));
                end
                tot += q_data[i].size();
            end
            if (tot == 0) push(r % N, 8'($urandom), 1'b1);
            drive_lanes();
            run_bytes(1, 1, 40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
